// File: rtl/systolic_sequencer.sv
// Command sequencer for the systolic array: takes LOAD_W/COMPUTE commands, drives PEmode/out_valid,
// waits on the array's done flags with a timeout, and returns the result on a response channel.
module systolic_sequencer #(
  parameter int PE_ROW  = 4,
  parameter int PE_COL  = 4,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_op,
  input  logic [PE_ROW*PE_COL*DWIDTH-1:0] cmd_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [PE_ROW*PE_COL*DWIDTH-1:0] rsp_data,
  output logic                            rsp_err,
  output logic [PE_ROW*PE_COL*DWIDTH-1:0] sa_din,
  output logic [1:0]                      sa_pemode,
  output logic                            sa_out_valid,
  input  logic                            sa_load_done,
  input  logic                            sa_final_done,
  input  logic [PE_ROW*PE_COL*DWIDTH-1:0] sa_result,
  output logic                            weights_loaded,
  output logic                            busy
);
  // state | meaning
  // IDLE  | ready for a command
  // WLOAD | one-cycle weight-load strobe (PEmode 01)
  // WWAIT | waiting for load_is_finish, timeout armed
  // DLOAD | one-cycle data-load strobe (PEmode 11)
  // DCOMP | waiting for final_is_finish, timeout armed
  // DRAIN | one idle cycle with out_valid low to reset array indices
  // RESP  | response held until consumer takes it
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WLOAD, WWAIT, DLOAD, DCOMP, DRAIN, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          accept, timeout;
  logic [1:0]    pemode_next;
  logic          out_valid_next;

  assign accept  = cmd_valid && cmd_ready;
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_next     = state;
    pemode_next    = 2'b00;
    out_valid_next = 1'b0;
    case (state)
      IDLE:  if (accept) begin
               if (!cmd_op)             state_next = WLOAD;
               else if (weights_loaded) state_next = DLOAD;
               else                     state_next = RESP;
             end
      WLOAD: state_next = WWAIT;
      WWAIT: if (sa_load_done || timeout) state_next = RESP;
      DLOAD: state_next = DCOMP;
      DCOMP: if (sa_final_done || timeout) state_next = DRAIN;
      DRAIN: state_next = RESP;
      RESP:  if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    case (state_next)
      WLOAD:        begin pemode_next = 2'b01; out_valid_next = 1'b1; end
      WWAIT:        out_valid_next = 1'b1;
      DLOAD, DCOMP: begin pemode_next = 2'b11; out_valid_next = 1'b1; end
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      cmd_ready      <= 1'b0;
      busy           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      sa_din         <= '0;
      sa_pemode      <= 2'b00;
      sa_out_valid   <= 1'b0;
      weights_loaded <= 1'b0;
    end else begin
      state        <= state_next;
      cmd_ready    <= (state_next == IDLE);
      busy         <= (state_next != IDLE);
      rsp_valid    <= (state_next == RESP);
      sa_pemode    <= pemode_next;
      sa_out_valid <= out_valid_next;
      cnt          <= (state == WWAIT || state == DCOMP) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (accept) begin
                rsp_data <= '0;
                rsp_err  <= cmd_op && !weights_loaded;
                if (state_next != RESP) sa_din <= cmd_data;
              end
        WWAIT: if (sa_load_done) begin
                 weights_loaded <= 1'b1;
                 rsp_err        <= 1'b0;
               end else if (timeout) begin
                 weights_loaded <= 1'b0;
                 rsp_err        <= 1'b1;
               end
        // done beats a coincident timeout
        DCOMP: if (sa_final_done) begin
                 rsp_data <= sa_result;
                 rsp_err  <= 1'b0;
               end else if (timeout) begin
                 rsp_data <= '0;
                 rsp_err  <= 1'b1;
               end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: expected responses queued at command time, compared at handshake.
module tb_systolic_sequencer;
  localparam int N = 4 * 4 * 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_op = 1'b0, rsp_ready = 1'b0;
  logic [N-1:0] cmd_data = '0, sa_result = '0;
  logic         sa_load_done = 1'b0, sa_final_done = 1'b0;
  logic         cmd_ready, rsp_valid, rsp_err, sa_out_valid, weights_loaded, busy;
  logic [N-1:0] rsp_data, sa_din;
  logic [1:0]   sa_pemode;

  systolic_sequencer #(.PE_ROW(4), .PE_COL(4), .DWIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .sa_din(sa_din), .sa_pemode(sa_pemode), .sa_out_valid(sa_out_valid),
    .sa_load_done(sa_load_done), .sa_final_done(sa_final_done), .sa_result(sa_result),
    .weights_loaded(weights_loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [N-1:0] data; } rsp_t;
  rsp_t sb[$];
  int checks = 0, errors = 0;
  logic [N-1:0] ident, mat_a, mat_b;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic err, logic [N-1:0] data);
    rsp_t e;
    e.err = err; e.data = data;
    sb.push_back(e);
  endtask

  task automatic send(logic op, logic [N-1:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 40) begin step(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(string tag);
    rsp_t e;
    int n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_scoreboard observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, rsp_err, e.err);
      chk({tag, "_data"}, rsp_data, e.data);
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
    chk({tag, "_idle_ready"}, cmd_ready, 1);
  endtask

  initial begin
    rsp_t e;
    ident = '0;
    for (int i = 0; i < 4; i++) ident[(i*4+i)*32 +: 32] = 32'd1;
    for (int k = 0; k < 16; k++) begin
      mat_a[k*32 +: 32] = 32'(k + 1);
      mat_b[k*32 +: 32] = 32'(100 + 3*k);
    end

    // reset state
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pemode", sa_pemode, 0);
    chk("rst_out_valid", sa_out_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_din", sa_din, 0);
    chk("rst_weights", weights_loaded, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", cmd_ready, 1);

    // COMPUTE without weights
    push(1'b1, '0);
    send(1'b1, mat_a);
    chk("now_pemode", sa_pemode, 0);
    chk("now_rsp_valid", rsp_valid, 1);
    wait_rsp("noweights");

    // LOAD_W identity
    push(1'b0, '0);
    send(1'b0, ident);
    chk("wload_pemode", sa_pemode, 2'b01);
    chk("wload_ov", sa_out_valid, 1);
    chk("wload_din", sa_din, ident);
    step();
    chk("wwait_pemode", sa_pemode, 0);
    chk("wwait_ov", sa_out_valid, 1);
    sa_load_done = 1'b1; step(); sa_load_done = 1'b0;
    chk("wload_weights", weights_loaded, 1);
    wait_rsp("loadw");

    // COMPUTE A
    push(1'b0, mat_a);
    send(1'b1, mat_a);
    chk("dload_pemode", sa_pemode, 2'b11);
    chk("dload_din", sa_din, mat_a);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dcomp_pemode", sa_pemode, 2'b11);
      chk("dcomp_ov", sa_out_valid, 1);
    end
    sa_result = mat_a; sa_final_done = 1'b1; step(); sa_final_done = 1'b0;
    chk("drain_pemode", sa_pemode, 0);
    chk("drain_ov", sa_out_valid, 0);
    wait_rsp("compute");

    // DCOMP timeout: error 16 cycles after entry
    push(1'b1, '0);
    send(1'b1, mat_b);
    step();
    for (int i = 0; i < 15; i++) step();
    chk("to_pre_err", rsp_err, 0);
    chk("to_pre_pemode", sa_pemode, 2'b11);
    step();
    chk("to_err", rsp_err, 1);
    chk("to_drain_pemode", sa_pemode, 0);
    wait_rsp("timeout");
    chk("to_weights_kept", weights_loaded, 1);

    // done on the last count beats timeout
    push(1'b0, mat_b);
    send(1'b1, mat_b);
    step();
    for (int i = 0; i < 15; i++) step();
    sa_result = mat_b; sa_final_done = 1'b1; step(); sa_final_done = 1'b0;
    wait_rsp("done_wins");

    // backpressure on response with a command waiting
    push(1'b0, '0);
    send(1'b0, ident);
    chk("reload_weights_kept", weights_loaded, 1);
    step();
    sa_load_done = 1'b1; step(); sa_load_done = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = mat_a;
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_err", rsp_err, e.err);
      chk("bp_data", rsp_data, e.data);
      step();
    end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("bp_drop", rsp_valid, 0);
    chk("bp_ready_next", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("bp_accept_busy", busy, 1);
    chk("bp_accept_pemode", sa_pemode, 2'b11);
    chk("bp_accept_din", sa_din, mat_a);

    // reset during DCOMP
    step();
    rst = 1'b1; step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pemode", sa_pemode, 0);
    chk("mid_rst_ov", sa_out_valid, 0);
    chk("mid_rst_weights", weights_loaded, 0);
    chk("mid_rst_din", sa_din, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    rst = 1'b0;
    sa_final_done = 1'b1; sa_load_done = 1'b1; step();
    sa_final_done = 1'b0; sa_load_done = 1'b0; step();
    chk("late_done_rsp", rsp_valid, 0);
    chk("late_done_busy", busy, 0);
    chk("late_load_weights", weights_loaded, 0);
    chk("late_ready", cmd_ready, 1);

    // WWAIT timeout clears weights; next COMPUTE errors
    push(1'b1, '0);
    send(1'b0, ident);
    wait_rsp("wtimeout");
    chk("wto_weights", weights_loaded, 0);
    push(1'b1, '0);
    send(1'b1, mat_a);
    wait_rsp("post_wto");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
